boot_load_ctrl: RTL and testbench
=================================

Name: boot_load_ctrl

Overview:
- Controls the whole power-on-to-poweroff lifetime of the processor core.
- Takes the program image byte-by-byte from the UART receiver and assembles little-endian 32-bit words.
- Writes those words into main memory through the shared memory write port while holding the core in reset.
- After the image is loaded, hands the write port to the core. After the core powers off, waits for the UART TX path to drain, then asserts halt.

Parameters:
MEMWORDS, 4096, number of 32-bit words loaded before the core is released
ADDR_W, 12, word-address width; must satisfy 2^ADDR_W >= MEMWORDS

Ports:
clk  in  1  system clock; all state updates on posedge
rst_n  in  1  synchronous active-low reset, sampled on posedge clk
rx_valid  in  1  one-cycle strobe: rx_data holds a received byte
rx_data  in  8  received byte
core_mem_we  in  1  core memory write enable
core_mem_addr  in  ADDR_W  core word address
core_mem_wdata  in  32  core write data
core_poweroff  in  1  core has executed its poweroff request (level)
tx_idle  in  1  TX queue empty, transmitter ready, no byte being enqueued
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory word address
mem_wdata  out  32  memory write data
core_rst  out  1  active-high core reset
load_done  out  1  image fully written (sticky until reset)
halted  out  1  simulation/system may stop (sticky until reset)
rx_overrun  out  1  sticky: byte received outside LOAD

Behaviour:
- States: LOAD, RUN, DRAIN, HALT (2-bit encoding).
- Reset (rst_n=0 at posedge):
  - state=LOAD, byte_idx=0, addr=0, shift=0.
  - Registered mem_we=0, mem_addr=0, mem_wdata=0.
  - core_rst=1, load_done=0, halted=0, rx_overrun=0.
  - A partially assembled word is discarded.
  - Reset mid-RUN or mid-DRAIN returns to LOAD and requires a full reload.
- LOAD:
  - On rx_valid: shift <= {rx_data, shift[31:8]}; byte_idx <= byte_idx+1 (mod 4). The first byte of a word ends up in bits [7:0].
  - Gaps of any length between strobes have no effect on the assembled word.
  - Registered write: on the edge where rx_valid is sampled with byte_idx==3, set mem_we<=1, mem_addr<=addr, mem_wdata<={rx_data, shift[31:8]}, addr<=addr+1. The pulse is exactly one cycle wide, visible in the cycle after the 4th byte. Otherwise mem_we<=0.
  - On the same edge, if addr==MEMWORDS-1: state<=RUN and load_done<=1.
  - Core memory inputs are ignored in LOAD.
- RUN:
  - On the first edge in RUN, core_rst<=0. The core therefore leaves reset one cycle after the final loader write pulse.
  - Memory port is a combinational pass-through: mem_we=core_mem_we, mem_addr=core_mem_addr, mem_wdata=core_mem_wdata (zero-latency).
  - core_poweroff=1 at an edge moves state to DRAIN. A core write in that same cycle still passes through.
- DRAIN:
  - mem_we=0 (core writes blocked). core_rst stays 0, so UART-output logic driven by the core remains live.
  - tx_idle=1 at an edge: state<=HALT and halted<=1.
- HALT:
  - core_rst<=1 on entry, mem_we=0.
  - Terminal; only reset exits.
- rx_valid sampled in RUN, DRAIN or HALT: byte dropped, rx_overrun<=1 (sticky).
- Output muxing: registered loader outputs are driven in LOAD; core pass-through in RUN; zeros in DRAIN and HALT.
- core_rst must never be 0 while state==LOAD.

Test Plan:
- MEMWORDS=4. Bytes 13,00,00,00 on sparse rx_valid (3-cycle gaps) -> exactly one cycle of mem_we=1 with addr 0, wdata 0x00000013, one cycle after the 4th strobe.
- 16 bytes 00..0F back-to-back -> four pulses: addr 0..3, wdata 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C. load_done=1 with the last pulse; core_rst falls one cycle later.
- In RUN: core_mem_we=1, addr 2, wdata 0xDEADBEEF -> same-cycle mem outputs match. rx_valid with 0x55 -> no write, rx_overrun=1.
- core_poweroff=1 with tx_idle=0 for 10 cycles -> halted=0, mem_we=0 despite core_mem_we=1. tx_idle=1 -> halted=1 and core_rst=1 at the next edge.
- Reset after 6 of 16 bytes, then 16 fresh bytes -> first pulse at addr 0 with a word made only of new bytes; all flags 0 during reset.
- Reset asserted in HALT -> state LOAD, halted=0, load_done=0, core_rst=1, rx_overrun cleared.

Source files
------------

// File: rtl/boot_load_ctrl.sv
// Boot loader / lifetime controller: assembles the UART image into memory words,
// releases the core, then sequences poweroff -> TX drain -> halt.
module boot_load_ctrl #(
  parameter int MEMWORDS = 4096,
  parameter int ADDR_W   = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              core_mem_we,
  input  logic [ADDR_W-1:0] core_mem_addr,
  input  logic [31:0]       core_mem_wdata,
  input  logic              core_poweroff,
  input  logic              tx_idle,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_rst,
  output logic              load_done,
  output logic              halted,
  output logic              rx_overrun,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEMWORDS - 1);

  state_t            state_q;
  logic [1:0]        byte_idx_q;
  logic [ADDR_W-1:0] addr_q;
  logic [23:0]       shift_q;
  logic              ld_we_q;
  logic [ADDR_W-1:0] ld_addr_q;
  logic [31:0]       ld_wdata_q;
  logic              core_rst_q;
  logic              load_done_q;
  logic              halted_q;
  logic              rx_overrun_q;
  logic [31:0]       word_d;

  // Only the upper three bytes of the shifter matter: the oldest byte drops
  // out as each new byte enters at the top.
  assign word_d = {rx_data, shift_q};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_LOAD;
      byte_idx_q   <= 2'd0;
      addr_q       <= '0;
      shift_q      <= '0;
      ld_we_q      <= 1'b0;
      ld_addr_q    <= '0;
      ld_wdata_q   <= '0;
      core_rst_q   <= 1'b1;
      load_done_q  <= 1'b0;
      halted_q     <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else begin
      ld_we_q <= 1'b0;
      case (state_q)
        ST_LOAD: begin
          if (rx_valid) begin
            shift_q    <= word_d[31:8];
            byte_idx_q <= byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
              ld_we_q    <= 1'b1;
              ld_addr_q  <= addr_q;
              ld_wdata_q <= word_d;
              addr_q     <= addr_q + 1'b1;
              if (addr_q == LAST_ADDR) begin
                state_q     <= ST_RUN;
                load_done_q <= 1'b1;
              end
            end
          end
        end
        ST_RUN: begin
          core_rst_q <= 1'b0;
          if (core_poweroff) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (tx_idle) begin
            state_q    <= ST_HALT;
            halted_q   <= 1'b1;
            core_rst_q <= 1'b1;
          end
        end
        default: ;
      endcase
      if (rx_valid && (state_q != ST_LOAD)) rx_overrun_q <= 1'b1;
    end
  end

  // The final loader pulse lands in the first RUN cycle while the core is
  // still held in reset, so the loader keeps the port until core_rst drops.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if ((state_q == ST_LOAD) || ((state_q == ST_RUN) && core_rst_q)) begin
      mem_we    = ld_we_q;
      mem_addr  = ld_addr_q;
      mem_wdata = ld_wdata_q;
    end else if (state_q == ST_RUN) begin
      mem_we    = core_mem_we;
      mem_addr  = core_mem_addr;
      mem_wdata = core_mem_wdata;
    end
  end

  assign core_rst   = core_rst_q;
  assign load_done  = load_done_q;
  assign halted     = halted_q;
  assign rx_overrun = rx_overrun_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_boot_load_ctrl.sv
// Randomized self-checking bench for boot_load_ctrl with a small image (4 words).
module tb_boot_load_ctrl;
  localparam int MEMWORDS = 4;
  localparam int ADDR_W   = 12;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = '0;
  logic              core_mem_we = 1'b0;
  logic [ADDR_W-1:0] core_mem_addr = '0;
  logic [31:0]       core_mem_wdata = '0;
  logic              core_poweroff = 1'b0;
  logic              tx_idle = 1'b0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              core_rst;
  logic              load_done;
  logic              halted;
  logic              rx_overrun;
  logic [1:0]        dbg_state;

  int total = 0;
  int bad = 0;
  int wr_cnt = 0;
  logic [7:0] img_q[$];

  boot_load_ctrl #(.MEMWORDS(MEMWORDS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .core_mem_we(core_mem_we), .core_mem_addr(core_mem_addr),
    .core_mem_wdata(core_mem_wdata), .core_poweroff(core_poweroff),
    .tx_idle(tx_idle), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .core_rst(core_rst), .load_done(load_done),
    .halted(halted), .rx_overrun(rx_overrun), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Reset with every flag and memory output checked while reset is held.
  task test_reset();
    @(negedge clk);
    rst_n = 1'b0; rx_valid = 1'b0; core_mem_we = 1'b0;
    core_poweroff = 1'b0; tx_idle = 1'b0;
    @(negedge clk);
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
    total++; if (mem_addr !== '0) begin bad++; $display("FAIL reset_mem_addr got=%0h exp=0", mem_addr); end
    total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
    total++; if (core_rst !== 1'b1) begin bad++; $display("FAIL reset_core_rst got=%b exp=1", core_rst); end
    total++; if (load_done !== 1'b0) begin bad++; $display("FAIL reset_load_done got=%b exp=0", load_done); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b exp=0", halted); end
    total++; if (rx_overrun !== 1'b0) begin bad++; $display("FAIL reset_rx_overrun got=%b exp=0", rx_overrun); end
    rst_n = 1'b1;
    wr_cnt = 0;
  endtask

  task fill_rand(input int n);
    img_q.delete();
    for (int i = 0; i < n; i++) img_q.push_back(8'($urandom_range(0, 255)));
  endtask

  // Sends the first n image bytes with random gaps. Model: byte k of the image
  // is byte (k mod 4) of word k/4, little-endian; word j goes to address j.
  task send_image(input int n, input int gmin, input int gmax);
    logic [31:0] exp_word;
    int g;
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      rx_valid = 1'b1; rx_data = img_q[i];
      @(negedge clk);
      rx_valid = 1'b0;
      if ((i % 4) == 3) begin
        exp_word = 32'(img_q[i-3]) + (32'(img_q[i-2]) << 8)
                 + (32'(img_q[i-1]) << 16) + (32'(img_q[i]) << 24);
        total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL load_pulse byte=%0d got=%b exp=1", i, mem_we); end
        total++; if (mem_addr !== ADDR_W'(wr_cnt)) begin bad++; $display("FAIL load_addr got=%0d exp=%0d", mem_addr, wr_cnt); end
        total++; if (mem_wdata !== exp_word) begin bad++; $display("FAIL load_wdata got=%h exp=%h", mem_wdata, exp_word); end
        total++; if (load_done !== (wr_cnt + 1 == MEMWORDS)) begin bad++; $display("FAIL load_done_flag got=%b word=%0d", load_done, wr_cnt); end
        total++; if (core_rst !== 1'b1) begin bad++; $display("FAIL load_core_rst got=%b exp=1", core_rst); end
        wr_cnt++;
      end else begin
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL load_no_pulse byte=%0d got=%b exp=0", i, mem_we); end
      end
      g = $urandom_range(gmin, gmax);
      repeat (g) begin
        @(negedge clk);
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL gap_no_pulse got=%b exp=0", mem_we); end
      end
    end
  endtask

  task test_sparse();
    test_reset();
    img_q = '{8'h13, 8'h00, 8'h00, 8'h00};
    send_image(4, 3, 3);
    total++; if (load_done !== 1'b0) begin bad++; $display("FAIL sparse_load_done got=%b exp=0", load_done); end
    total++; if (core_rst !== 1'b1) begin bad++; $display("FAIL sparse_core_rst got=%b exp=1", core_rst); end
  endtask

  task test_back_to_back();
    test_reset();
    img_q.delete();
    for (int i = 0; i < 16; i++) img_q.push_back(8'(i));
    send_image(16, 0, 0);
    @(negedge clk);
    total++; if (core_rst !== 1'b0) begin bad++; $display("FAIL b2b_core_release got=%b exp=0", core_rst); end
    total++; if (rx_overrun !== 1'b0) begin bad++; $display("FAIL b2b_overrun got=%b exp=0", rx_overrun); end
  endtask

  task test_run();
    logic [ADDR_W-1:0] a;
    logic [31:0] d;
    logic w;
    core_mem_we = 1'b1; core_mem_addr = 12'd2; core_mem_wdata = 32'hDEADBEEF;
    #1;
    total++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 12'd2, 32'hDEADBEEF}) begin bad++; $display("FAIL run_pass got=%b/%0h/%h exp=1/2/deadbeef", mem_we, mem_addr, mem_wdata); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      w = 1'($urandom_range(0, 1)); a = ADDR_W'($urandom); d = $urandom;
      core_mem_we = w; core_mem_addr = a; core_mem_wdata = d;
      #1;
      total++; if ({mem_we, mem_addr, mem_wdata} !== {w, a, d}) begin bad++; $display("FAIL run_pass_rand got=%b/%0h/%h exp=%b/%0h/%h", mem_we, mem_addr, mem_wdata, w, a, d); end
    end
    @(negedge clk);
    core_mem_we = 1'b0; rx_valid = 1'b1; rx_data = 8'h55;
    @(negedge clk);
    rx_valid = 1'b0;
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL run_rx_no_write got=%b exp=0", mem_we); end
    total++; if (rx_overrun !== 1'b1) begin bad++; $display("FAIL run_rx_overrun got=%b exp=1", rx_overrun); end
    total++; if (core_rst !== 1'b0) begin bad++; $display("FAIL run_core_rst got=%b exp=0", core_rst); end
  endtask

  task test_drain();
    @(negedge clk);
    core_mem_we = 1'b1; core_mem_addr = 12'd7; core_mem_wdata = 32'h1234_5678;
    core_poweroff = 1'b1; tx_idle = 1'b0;
    #1;
    total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL poweroff_cycle_write got=%b exp=1", mem_we); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++; if (halted !== 1'b0) begin bad++; $display("FAIL drain_halted cyc=%0d got=%b exp=0", i, halted); end
      total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL drain_blocked cyc=%0d got=%b exp=0", i, mem_we); end
      total++; if (core_rst !== 1'b0) begin bad++; $display("FAIL drain_core_rst cyc=%0d got=%b exp=0", i, core_rst); end
    end
    tx_idle = 1'b1;
    @(negedge clk);
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_flag got=%b exp=1", halted); end
    total++; if (core_rst !== 1'b1) begin bad++; $display("FAIL halt_core_rst got=%b exp=1", core_rst); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL halt_mem_we got=%b exp=0", mem_we); end
    core_poweroff = 1'b0; tx_idle = 1'b0;
    repeat (3) @(negedge clk);
    total++; if ({halted, core_rst, load_done, mem_we} !== 4'b1110) begin bad++; $display("FAIL halt_terminal got=%b exp=1110", {halted, core_rst, load_done, mem_we}); end
  endtask

  task test_partial_reset();
    test_reset();
    fill_rand(6);
    send_image(6, 0, 2);
    fill_rand(16);
    test_reset();
    send_image(16, 0, 3);
    @(negedge clk);
    total++; if (core_rst !== 1'b0) begin bad++; $display("FAIL reload_core_release got=%b exp=0", core_rst); end
    total++; if (load_done !== 1'b1) begin bad++; $display("FAIL reload_load_done got=%b exp=1", load_done); end
  endtask

  initial begin
    test_reset();
    test_sparse();
    test_back_to_back();
    test_run();
    test_drain();
    test_reset();
    test_partial_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1, "timeout");
  end
endmodule
